// File: rtl/grey6_rx_decode.sv
// grey6_rx_decode: consumer of a 6-bit Gray-code counter from another clock domain.
// Synchronises grey_in into clk, converts it to binary and checks that each
// change is exactly +1 modulo 64. It emits one-cycle step/err pulses, a
// wrapping step count and an error count that saturates at 255.
//
// Ports:
//   clk      local clock
//   w_rst    synchronous active-high reset
//   grey_in  asynchronous Gray-coded count from upstream
//   bin      binary value of the last accepted sample (registered)
//   step     one-cycle pulse per legal +1 advance
//   err      one-cycle pulse per illegal transition while locked
//   locked   high while tracking a legal sequence
//   step_cnt step pulse count, wraps modulo 2^ACC_W
//   err_cnt  err pulse count, saturates at 255
//
// SYNC_STAGES legal range is 2..4.
module grey6_rx_decode #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACC_W       = 16
) (
  input  logic             clk,
  input  logic             w_rst,
  input  logic [5:0]       grey_in,
  output logic [5:0]       bin,
  output logic             step,
  output logic             err,
  output logic             locked,
  output logic [ACC_W-1:0] step_cnt,
  output logic [7:0]       err_cnt
);

  localparam int unsigned GW     = 6;
  localparam int unsigned FILL_W = 3;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t                        state;
  logic [FILL_W-1:0]             fill_cnt;
  logic [SYNC_STAGES-1:0][GW-1:0] sync_q;
  logic [GW-1:0]                 g_s;
  logic [GW-1:0]                 b_s;
  logic [GW-1:0]                 prev_g;
  logic [GW-1:0]                 prev_b;
  logic [GW-1:0]                 g_diff;
  logic                          changed;
  logic                          legal;

  // Synchroniser chain; the oldest stage feeds the decoder.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], grey_in};
    end
  end

  assign g_s = sync_q[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    b_s       = '0;
    b_s[GW-1] = g_s[GW-1];
    for (int i = GW - 2; i >= 0; i--) begin
      b_s[i] = b_s[i+1] ^ g_s[i];
    end
  end

  // Legal step: single-bit Gray change whose binary value is prev+1 mod 64.
  assign g_diff  = g_s ^ prev_g;
  assign changed = |g_diff;
  assign legal   = changed && ($countones(g_diff) == 1) &&
                   (b_s == GW'(prev_b + GW'(1)));

  // Tracking state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      state    <= ST_FILL;
      fill_cnt <= '0;
      prev_g   <= '0;
      prev_b   <= '0;
      bin      <= '0;
      step     <= 1'b0;
      err      <= 1'b0;
      locked   <= 1'b0;
      step_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      step <= 1'b0;
      err  <= 1'b0;
      case (state)
        // Wait for the synchroniser to hold a post-reset sample, then adopt it.
        ST_FILL: begin
          if (fill_cnt == FILL_W'(SYNC_STAGES)) begin
            prev_g <= g_s;
            prev_b <= b_s;
            bin    <= b_s;
            state  <= ST_ACQUIRE;
          end else begin
            fill_cnt <= fill_cnt + FILL_W'(1);
          end
        end
        ST_ACQUIRE: begin
          if (changed) begin
            prev_g <= g_s;
            prev_b <= b_s;
            bin    <= b_s;
            if (legal) begin
              step     <= 1'b1;
              step_cnt <= step_cnt + ACC_W'(1);
              locked   <= 1'b1;
              state    <= ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (changed) begin
            prev_g <= g_s;
            prev_b <= b_s;
            bin    <= b_s;
            if (legal) begin
              step     <= 1'b1;
              step_cnt <= step_cnt + ACC_W'(1);
            end else begin
              err    <= 1'b1;
              locked <= 1'b0;
              state  <= ST_ACQUIRE;
              if (err_cnt != {CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + CNT_W'(1);
              end
            end
          end
        end
        default: begin
          state  <= ST_FILL;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grey6_rx_decode.sv
// Self-checking bench for grey6_rx_decode: directed scenarios plus a random
// walk, compared against a transition-level model of the tracking rules.
module tb_grey6_rx_decode;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned ACC_W = 8;
  localparam int unsigned LAT   = SYNC + 1;

  logic             clk;
  logic             w_rst;
  logic [5:0]       grey_in;
  logic [5:0]       bin;
  logic             step;
  logic             err;
  logic             locked;
  logic [ACC_W-1:0] step_cnt;
  logic [7:0]       err_cnt;

  int vectors;
  int miscompares;

  // Reference model: last accepted binary value, lock flag and counters.
  int m_prev;
  int m_locked;
  int m_steps;
  int m_errs;

  grey6_rx_decode #(.SYNC_STAGES(SYNC), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .w_rst    (w_rst),
    .grey_in  (grey_in),
    .bin      (bin),
    .step     (step),
    .err      (err),
    .locked   (locked),
    .step_cnt (step_cnt),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] gray(input int v);
    logic [5:0] b;
    b = 6'(v);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One-cycle reset with grey_in = v, then confirm the FILL window and adoption.
  task automatic rst_seq(input int v);
    grey_in = gray(v);
    w_rst   = 1'b1;
    @(negedge clk);
    w_rst = 1'b0;
    chk("rst_bin", bin, 0);
    chk("rst_step", step, 0);
    chk("rst_err", err, 0);
    chk("rst_locked", locked, 0);
    chk("rst_step_cnt", step_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fill_step", step, 0);
      chk("fill_err", err, 0);
      chk("fill_locked", locked, 0);
    end
    m_prev   = v;
    m_locked = 0;
    m_steps  = 0;
    m_errs   = 0;
    chk("fill_bin", bin, v);
  endtask

  // Drive a new value (called at a negedge) and check the response window.
  task automatic apply(input int v, input int idle);
    int old_prev;
    int e_step;
    int e_err;
    old_prev = m_prev;
    e_step   = 0;
    e_err    = 0;
    if (v != m_prev) begin
      if (v == (m_prev + 1) % 64) begin
        e_step   = 1;
        m_locked = 1;
        m_steps  = (m_steps + 1) % (1 << ACC_W);
      end else if (m_locked != 0) begin
        e_err    = 1;
        m_locked = 0;
        if (m_errs < 255) m_errs++;
      end
      m_prev = v;
    end
    grey_in = gray(v);
    for (int k = 1; k <= int'(LAT) + 1 + idle; k++) begin
      @(negedge clk);
      if (k < int'(LAT)) begin
        chk("early_pulse", int'(step) | int'(err), 0);
        chk("early_bin", bin, old_prev);
      end else if (k == int'(LAT)) begin
        chk("step", step, e_step);
        chk("err", err, e_err);
        chk("bin", bin, m_prev);
        chk("locked", locked, m_locked);
        chk("step_cnt", step_cnt, m_steps);
        chk("err_cnt", err_cnt, m_errs);
      end else begin
        chk("late_pulse", int'(step) | int'(err), 0);
      end
    end
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("hold_pulse", int'(step) | int'(err), 0);
      chk("hold_bin", bin, m_prev);
      chk("hold_locked", locked, m_locked);
      chk("hold_step_cnt", step_cnt, m_steps);
    end
  endtask

  initial begin
    int v;
    int r;
    vectors     = 0;
    miscompares = 0;
    m_prev      = 0;
    m_locked    = 0;
    m_steps     = 0;
    m_errs      = 0;
    w_rst       = 1'b1;
    grey_in     = '0;

    // Full lap 0..63 and wrap to 0, one step every 7 cycles.
    rst_seq(0);
    for (int i = 1; i <= 64; i++) apply(i % 64, 7 - int'(LAT) - 1);
    chk("lap_steps", step_cnt, 64);
    chk("lap_errs", err_cnt, 0);
    chk("lap_locked", locked, 1);

    // Hold steady at bin=12.
    for (int i = 1; i <= 12; i++) apply(i, 1);
    hold(100);

    // Forward jump while locked at 5, then recover with a legal step.
    rst_seq(0);
    for (int i = 1; i <= 5; i++) apply(i, 1);
    apply(9, 2);
    chk("jump_err_cnt", err_cnt, 1);
    apply(10, 2);
    chk("recover_locked", locked, 1);

    // Single-bit backward step while locked at 10.
    apply(9, 2);
    chk("back_locked", locked, 0);

    // Alternate lock and jump until err_cnt saturates.
    for (int i = 0; i < 300; i++) begin
      apply((m_prev + 1) % 64, 0);
      apply((m_prev + 20) % 64, 0);
    end
    chk("sat_err_cnt", err_cnt, 255);

    // Build step_cnt=40, err_cnt=3, locked, then reset with grey_in=17.
    rst_seq(0);
    for (int i = 1; i <= 37; i++) apply(i, 0);
    apply(40, 0); apply(41, 0);
    apply(20, 0); apply(21, 0);
    apply(50, 0); apply(51, 0);
    chk("pre_rst_step_cnt", step_cnt, 40);
    chk("pre_rst_err_cnt", err_cnt, 3);
    chk("pre_rst_locked", locked, 1);
    rst_seq(17);

    // Random walk biased toward legal steps.
    for (int i = 0; i < 250; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      v = (m_prev + 1) % 64;
      else if (r < 7) v = (m_prev + 63) % 64;
      else if (r < 8) v = m_prev;
      else            v = int'($urandom_range(0, 63));
      apply(v, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
